v_lsu_sequencer: RTL and testbench
==================================

V_LSU_SEQUENCER -- requirements
Module: v_lsu_sequencer

Interface
REQ-001 Parameter ADDR_W, default 14, is the bank group address width (dm_addr).
REQ-002 Parameter DATA_W, default 32, is the word width per bank.
REQ-003 Parameter VL_W, default 7, is the vector length width in words (max 127).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port core_clk  in  1  sole clock, all state on rising edge.
REQ-006 Port nrst  in  1  asynchronous active-low reset.
REQ-007 Port s_req  in  1  scalar core access request.
REQ-008 Port s_we  in  4  scalar byte write enables; 0 means read.
REQ-009 Port s_addr  in  ADDR_W+2  scalar word address; [1:0] is the bank, upper bits are the group.
REQ-010 Port s_wdata  in  DATA_W  scalar write word.
REQ-011 Port s_gnt  out  1  scalar access issued this cycle.
REQ-012 Port s_rvalid / s_rdata  out  1 / DATA_W  scalar read return.
REQ-013 Port v_start  in  1  vector job start pulse.
REQ-014 Port v_store  in  1  job is a store (1) or a load (0).
REQ-015 Port v_base  in  ADDR_W  starting group address.
REQ-016 Port v_vl  in  VL_W  job length in words.
REQ-017 Port v_wdata  in  4*DATA_W  store beat, word i goes to bank i.
REQ-018 Port v_wready  out  1  v_wdata consumed this cycle.
REQ-019 Port v_rvalid / v_rdata / v_rmask  out  1 / 4*DATA_W / 4  load beat return and valid-word mask.
REQ-020 Port v_busy / v_done  out  1 / 1  job active / one-cycle completion pulse.
REQ-021 Port dm_addr  out  ADDR_W  group address to all banks.
REQ-022 Port dm_write  out  16  byte enables, [4i+3:4i] for bank i.
REQ-023 Port dm_wdata / dm_rdata  out / in  4*DATA_W  bank data; dm_rdata is valid one cycle after issue.

Function
REQ-024 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-025 IDLE: on v_start with v_vl!=0, latch base, vl and store, then go to RUN; with v_vl==0, pulse v_done next cycle and stay in IDLE.
REQ-026 v_start SHALL be ignored outside IDLE.
REQ-027 v_busy=1 in RUN and DRAIN.
REQ-028 IDLE: a scalar s_req SHALL always be granted in the same cycle (s_gnt combinational).
REQ-029 RUN arbitration: scalar SHALL win unless the scalar was granted in the previous cycle.
- With s_req held high, grants alternate scalar/vector.
REQ-030 Vector beat: dm_addr=cur_addr; mask=4'hF if rem>=4, else (1<<rem)-1; then rem-=min(rem,4) and cur_addr+=1 modulo 2^ADDR_W (wraps).
REQ-031 Store beat: dm_write bank i={4{mask[i]}}, dm_wdata=v_wdata, v_wready=1 for that cycle only.
REQ-032 Load beat: dm_write=0, then next cycle v_rvalid=1, v_rdata=dm_rdata, v_rmask=registered mask.
REQ-033 After the beat with rem reaching 0, go to DRAIN; DRAIN asserts v_done for one cycle (together with the final v_rvalid on loads), then goes to IDLE.
REQ-034 Scalar grant: dm_addr=s_addr[ADDR_W+1:2]; dm_write bank s_addr[1:0]=s_we, other banks 0; dm_wdata=s_wdata replicated ×4.
REQ-035 Scalar read (s_we==0): s_rvalid=1 next cycle, s_rdata=word of dm_rdata at the registered bank index.
REQ-036 When no access is issued, dm_write=0 and dm_addr holds its last value.

Reset
REQ-037 nrst low SHALL immediately force the following:
- state IDLE; v_busy, v_done, v_rvalid, s_rvalid, s_gnt, v_wready = 0; dm_write=0.
- cur_addr, rem and masks = 0.
REQ-038 Reset mid-job SHALL abandon the job without a v_done pulse; the first v_start after release is accepted.

Verification
REQ-039 Load v_base=0x010, v_vl=10, s_req=0 -> beats at 0x010/0x011/0x012; v_rvalid on the next 3 cycles with masks F,F,3; v_done coincides with the third v_rvalid.
REQ-040 Store v_vl=8, s_req held high, s_we=4'hF -> grants alternate S,V,S,V; v_wready exactly twice; dm_write=16'hFFFF on vector beats; v_done 1 cycle after the second vector beat.
REQ-041 v_start with v_vl=0 -> v_done=1 next cycle; v_busy stays 0; dm_write=0 throughout.
REQ-042 v_base=0x3FFF, v_vl=8, load -> dm_addr 0x3FFF then 0x0000 (wrap).
REQ-043 Scalar read s_addr bank=2 in IDLE -> s_gnt same cycle; next cycle s_rvalid=1, s_rdata=dm_rdata[95:64].
REQ-044 nrst pulsed low during RUN of a vl=12 load -> outputs 0 at once; no v_done; next v_start runs normally.

Source files
------------

// File: rtl/v_lsu_sequencer_if.sv
// Scalar-core, vector-job and data-memory bank signals of the LSU sequencer.
// slave is the sequencer's view; master is the core/memory environment.
interface v_lsu_sequencer_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int VL_W   = 7
);
   logic                  s_req;
   logic [3:0]            s_we;
   logic [ADDR_W+1:0]     s_addr;
   logic [DATA_W-1:0]     s_wdata;
   logic                  s_gnt;
   logic                  s_rvalid;
   logic [DATA_W-1:0]     s_rdata;

   logic                  v_start;
   logic                  v_store;
   logic [ADDR_W-1:0]     v_base;
   logic [VL_W-1:0]       v_vl;
   logic [4*DATA_W-1:0]   v_wdata;
   logic                  v_wready;
   logic                  v_rvalid;
   logic [4*DATA_W-1:0]   v_rdata;
   logic [3:0]            v_rmask;
   logic                  v_busy;
   logic                  v_done;

   logic [ADDR_W-1:0]     dm_addr;
   logic [15:0]           dm_write;
   logic [4*DATA_W-1:0]   dm_wdata;
   logic [4*DATA_W-1:0]   dm_rdata;

   modport slave (
      input  s_req, s_we, s_addr, s_wdata,
      output s_gnt, s_rvalid, s_rdata,
      input  v_start, v_store, v_base, v_vl, v_wdata,
      output v_wready, v_rvalid, v_rdata, v_rmask, v_busy, v_done,
      output dm_addr, dm_write, dm_wdata,
      input  dm_rdata
   );

   modport master (
      output s_req, s_we, s_addr, s_wdata,
      input  s_gnt, s_rvalid, s_rdata,
      output v_start, v_store, v_base, v_vl, v_wdata,
      input  v_wready, v_rvalid, v_rdata, v_rmask, v_busy, v_done,
      input  dm_addr, dm_write, dm_wdata,
      output dm_rdata
   );
endinterface

// File: rtl/v_lsu_sequencer.sv
// Sequences vector load/store jobs over a 4-bank word memory, interleaving
// scalar core accesses; the scalar side is granted combinationally.
module v_lsu_sequencer #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int VL_W   = 7
) (
   input  logic                  core_clk,
   input  logic                  nrst,
   v_lsu_sequencer_if.slave      bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [VL_W-1:0]     rem_q, rem_d;
   logic                store_q, store_d;
   logic                zdone_q, zdone_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                sgnt_last_q;
   logic                s_rd_q;
   logic [1:0]          s_bank_q;
   logic                v_ld_q;
   logic [3:0]          v_mask_q;

   logic                s_gnt_c;
   logic                vec_beat_c;
   logic [3:0]          mask_c;
   logic [ADDR_W-1:0]   dm_addr_c;
   logic [15:0]         dm_write_c;
   logic [4*DATA_W-1:0] dm_wdata_c;
   logic                v_wready_c;

   function automatic logic [3:0] beat_mask(input logic [VL_W-1:0] r);
      if (r >= VL_W'(4)) return 4'hF;
      case (r[1:0])
         2'd1:    return 4'h1;
         2'd2:    return 4'h3;
         2'd3:    return 4'h7;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [15:0] expand_mask(input logic [3:0] m);
      logic [15:0] e;
      for (int i = 0; i < 4; i++) e[4*i +: 4] = {4{m[i]}};
      return e;
   endfunction

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      store_d    = store_q;
      zdone_d    = 1'b0;
      s_gnt_c    = 1'b0;
      vec_beat_c = 1'b0;
      mask_c     = beat_mask(rem_q);
      dm_addr_c  = addr_q;
      dm_write_c = 16'h0000;
      dm_wdata_c = '0;
      v_wready_c = 1'b0;

      case (state_q)
         IDLE: begin
            s_gnt_c = bus.s_req;
            if (bus.v_start) begin
               if (bus.v_vl != '0) begin
                  cur_addr_d = bus.v_base;
                  rem_d      = bus.v_vl;
                  store_d    = bus.v_store;
                  state_d    = RUN;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Scalar wins unless it also won last cycle, so a held s_req alternates.
            s_gnt_c    = bus.s_req && !sgnt_last_q;
            vec_beat_c = !s_gnt_c;
            if (vec_beat_c) begin
               cur_addr_d = cur_addr_q + ADDR_W'(1);
               rem_d      = (rem_q >= VL_W'(4)) ? rem_q - VL_W'(4) : '0;
               if (rem_q <= VL_W'(4)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            s_gnt_c = bus.s_req;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset must silence the combinational grant immediately.
      if (!nrst) s_gnt_c = 1'b0;

      if (s_gnt_c) begin
         dm_addr_c  = bus.s_addr[ADDR_W+1:2];
         dm_write_c = {12'h000, bus.s_we} << {bus.s_addr[1:0], 2'b00};
         dm_wdata_c = {4{bus.s_wdata}};
      end else if (vec_beat_c) begin
         dm_addr_c = cur_addr_q;
         if (store_q) begin
            dm_write_c = expand_mask(mask_c);
            dm_wdata_c = bus.v_wdata;
            v_wready_c = 1'b1;
         end
      end
   end

   always_ff @(posedge core_clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         rem_q       <= '0;
         store_q     <= 1'b0;
         zdone_q     <= 1'b0;
         addr_q      <= '0;
         sgnt_last_q <= 1'b0;
         s_rd_q      <= 1'b0;
         s_bank_q    <= 2'd0;
         v_ld_q      <= 1'b0;
         v_mask_q    <= 4'h0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         rem_q       <= rem_d;
         store_q     <= store_d;
         zdone_q     <= zdone_d;
         sgnt_last_q <= s_gnt_c;
         s_rd_q      <= s_gnt_c && (bus.s_we == 4'h0);
         v_ld_q      <= vec_beat_c && !store_q;
         if (s_gnt_c || vec_beat_c) addr_q <= dm_addr_c;
         if (s_gnt_c) s_bank_q <= bus.s_addr[1:0];
         if (vec_beat_c) v_mask_q <= mask_c;
      end
   end

   assign bus.s_gnt    = s_gnt_c;
   assign bus.s_rvalid = s_rd_q;
   assign bus.s_rdata  = bus.dm_rdata[DATA_W*int'(s_bank_q) +: DATA_W];
   assign bus.v_wready = v_wready_c;
   assign bus.v_rvalid = v_ld_q;
   assign bus.v_rdata  = bus.dm_rdata;
   assign bus.v_rmask  = v_mask_q;
   assign bus.v_busy   = (state_q != IDLE);
   assign bus.v_done   = (state_q == DRAIN) || zdone_q;
   assign bus.dm_addr  = dm_addr_c;
   assign bus.dm_write = dm_write_c;
   assign bus.dm_wdata = dm_wdata_c;

endmodule

// File: tb/tb_v_lsu_sequencer.sv
// Randomized and directed bench for v_lsu_sequencer against a beat-list
// reference model; the bench also plays the memory driving dm_rdata.
module tb_v_lsu_sequencer;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int VW = 7;

   logic core_clk = 1'b0;
   logic nrst     = 1'b0;
   always #5 core_clk = ~core_clk;

   v_lsu_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .VL_W(VW)) bus();

   v_lsu_sequencer #(.ADDR_W(AW), .DATA_W(DW), .VL_W(VW)) dut (
      .core_clk (core_clk),
      .nrst     (nrst),
      .bus      (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [3:0]    mask;
   } beat_t;

   beat_t         bq[$];
   bit            m_store, m_drain, m_zdone, m_prev_s, m_rs, m_rv;
   logic [1:0]    m_rbank;
   logic [3:0]    m_rmask;
   logic [AW-1:0] m_last;

   task automatic model_reset();
      bq.delete();
      m_store = 0; m_drain = 0; m_zdone = 0; m_prev_s = 0; m_rs = 0; m_rv = 0;
      m_rbank = 2'd0; m_rmask = 4'h0; m_last = '0;
   endtask

   task automatic idle_inputs();
      bus.s_req = 0; bus.s_we = 4'h0; bus.s_addr = '0; bus.s_wdata = '0;
      bus.v_start = 0; bus.v_store = 0; bus.v_base = '0; bus.v_vl = '0;
      bus.v_wdata = '0; bus.dm_rdata = '0;
   endtask

   // One clock cycle: called at posedge+1 with inputs already applied.
   task automatic step();
      bit running, sg, vb, wr, busy_now;
      beat_t b;
      logic [15:0] ew;
      logic [AW-1:0] ea;
      logic [127:0] ewd;
      bus.dm_rdata = {$urandom, $urandom, $urandom, $urandom};
      running = (bq.size() > 0);
      sg = bus.s_req && !(running && m_prev_s);
      vb = running && !sg;
      b = vb ? bq[0] : '0;
      ew = 16'h0; ea = m_last; ewd = '0; wr = 0;
      if (sg) begin
         ea  = bus.s_addr[AW+1:2];
         ew  = 16'(bus.s_we) << (4 * int'(bus.s_addr[1:0]));
         ewd = {4{bus.s_wdata}};
         wr  = (bus.s_we != 0);
      end else if (vb) begin
         ea = b.addr;
         if (m_store) begin
            for (int i = 0; i < 4; i++) ew[4*i +: 4] = {4{b.mask[i]}};
            ewd = bus.v_wdata;
            wr  = 1;
         end
      end
      @(negedge core_clk);
      check_val("s_gnt", bus.s_gnt, sg);
      check_val("v_wready", bus.v_wready, vb && m_store);
      check_val("dm_addr", bus.dm_addr, ea);
      check_val("dm_write", bus.dm_write, ew);
      if (wr) check_val("dm_wdata", bus.dm_wdata, ewd);
      check_val("v_busy", bus.v_busy, running || m_drain);
      check_val("v_done", bus.v_done, m_drain || m_zdone);
      check_val("s_rvalid", bus.s_rvalid, m_rs);
      if (m_rs) check_val("s_rdata", bus.s_rdata, bus.dm_rdata[32*m_rbank +: 32]);
      check_val("v_rvalid", bus.v_rvalid, m_rv);
      if (m_rv) begin
         check_val("v_rdata", bus.v_rdata, bus.dm_rdata);
         check_val("v_rmask", bus.v_rmask, m_rmask);
      end
      busy_now = running || m_drain;
      if (vb) void'(bq.pop_front());
      m_drain  = vb && (bq.size() == 0);
      m_zdone  = !busy_now && bus.v_start && (bus.v_vl == 0);
      m_rs     = sg && (bus.s_we == 4'h0);
      if (sg) m_rbank = bus.s_addr[1:0];
      m_rv     = vb && !m_store;
      if (vb) m_rmask = b.mask;
      m_prev_s = sg;
      if (sg || vb) m_last = ea;
      if (!busy_now && bus.v_start && bus.v_vl != 0) begin
         int vl;
         vl = int'(bus.v_vl);
         m_store = bus.v_store;
         for (int k = 0; 4 * k < vl; k++) begin
            int w;
            beat_t nb;
            w = vl - 4 * k;
            if (w > 4) w = 4;
            nb.addr = AW'(int'(bus.v_base) + k);
            nb.mask = 4'((1 << w) - 1);
            bq.push_back(nb);
         end
      end
      @(posedge core_clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 nrst = 1'b0;
      #1;
      check_val("rst_s_gnt", bus.s_gnt, 1'b0);
      check_val("rst_v_busy", bus.v_busy, 1'b0);
      check_val("rst_v_done", bus.v_done, 1'b0);
      check_val("rst_v_rvalid", bus.v_rvalid, 1'b0);
      check_val("rst_s_rvalid", bus.s_rvalid, 1'b0);
      check_val("rst_v_wready", bus.v_wready, 1'b0);
      check_val("rst_dm_write", bus.dm_write, 16'h0);
      model_reset();
      @(posedge core_clk);
      #1 nrst = 1'b1;
   endtask

   task automatic start_job(input bit st, input logic [AW-1:0] base, input logic [VW-1:0] vl);
      bus.v_start = 1; bus.v_store = st; bus.v_base = base; bus.v_vl = vl;
      bus.v_wdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      bus.v_start = 0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      bus.s_req = 1;
      #3;
      check_val("init_s_gnt", bus.s_gnt, 1'b0);
      check_val("init_v_busy", bus.v_busy, 1'b0);
      check_val("init_dm_write", bus.dm_write, 16'h0);
      bus.s_req = 0;
      repeat (2) @(posedge core_clk);
      #1 nrst = 1'b1;
      step();

      // Load of 10 words from 0x010, no scalar traffic.
      start_job(0, 14'h010, 7'd10);
      repeat (5) step();

      // Store of 8 words with scalar writes held high.
      bus.s_req = 1; bus.s_we = 4'hF; bus.s_addr = 16'h1235; bus.s_wdata = 32'hCAFE_F00D;
      start_job(1, 14'h200, 7'd8);
      repeat (4) begin
         bus.v_wdata = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      bus.s_req = 0;
      repeat (2) step();

      // Zero-length job.
      start_job(0, 14'h055, 7'd0);
      repeat (2) step();

      // Address wrap at the top of the group space.
      start_job(0, 14'h3FFF, 7'd8);
      repeat (4) step();

      // Scalar read of bank 2 while idle.
      bus.s_req = 1; bus.s_we = 4'h0; bus.s_addr = {14'h123, 2'd2};
      step();
      bus.s_req = 0;
      step();

      // Reset in the middle of a 12-word load, then a fresh job.
      start_job(0, 14'h100, 7'd12);
      step();
      pulse_reset();
      start_job(0, 14'h040, 7'd5);
      repeat (4) step();

      // Randomized traffic with occasional resets.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int sreq_pct;
         sreq_pct = (cyc < 1300) ? 20 : (cyc < 2600) ? 60 : 95;
         bus.s_req   = ($urandom_range(0, 99) < sreq_pct);
         bus.s_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         bus.s_addr  = 16'($urandom);
         bus.s_wdata = $urandom;
         bus.v_start = ($urandom_range(0, 5) == 0);
         bus.v_store = $urandom_range(0, 1) == 1;
         bus.v_base  = ($urandom_range(0, 3) == 0) ? AW'(14'h3FF8 + $urandom_range(0, 7)) : AW'($urandom);
         bus.v_vl    = ($urandom_range(0, 7) == 0) ? 7'd0 : VW'($urandom_range(1, 20));
         bus.v_wdata = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 399) == 0) pulse_reset();
         else step();
      end

      idle_inputs();
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
